serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter W, default 32: operand and result width in bits, legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 sub  input  1  operation select: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 A  input  W  first operand; sampled with start.
REQ-007 B  input  W  second operand; sampled with start.
REQ-008 Result  output  W  sum or difference; registered; held until the next accepted start.
REQ-009 Cout  output  1  carry out of the MSB (for subtraction, 1 = no borrow).
REQ-010 Overflow  output  1  two's-complement signed overflow.
REQ-011 Zero  output  1  1 when Result equals 0.
REQ-012 busy  output  1  1 while in SHIFT.
REQ-013 valid  output  1  one-cycle pulse; Result and flags are final.

Function
REQ-014 States SHALL be IDLE, SHIFT and DONE, with reset state IDLE.
REQ-015 IDLE with start=1 SHALL do the following: load A into shift register SA; load B into SB when sub=0, or ~B when sub=1; set carry flop to sub; set bit counter to W-1; go to SHIFT.
REQ-016 SHIFT, every cycle: SHALL add SA[0], SB[0] and the carry flop in one full-adder cell, shift the sum bit into the result register from the MSB end, shift SA and SB right by one, and update the carry flop with the cell's carry output.
REQ-017 SHIFT SHALL capture the carry into the MSB, as Overflow support, on the cycle the counter equals 0.
REQ-018 SHIFT with counter=0 SHALL move to DONE; otherwise the counter SHALL decrement.
REQ-019 DONE SHALL assert valid for exactly one cycle, latch Cout from the carry flop, set Overflow = carry_into_MSB XOR Cout, set Zero = (Result==0), and return to IDLE.
REQ-020 Latency: with start accepted at edge N, valid SHALL be high in the cycle after edge N+W+1, i.e. W+2 clocks from start to valid.
REQ-021 start SHALL be ignored while busy=1 or valid=1; operands are not re-sampled.
REQ-022 start back-to-back with valid SHALL be accepted in the following IDLE cycle only; no operation queueing.
REQ-023 Arithmetic is modulo 2^W and SHALL match (A + B) or (A + ~B + 1) bit-exactly.
REQ-024 Result and flags SHALL keep their previous values during SHIFT until DONE updates the flags; the Result register is the shift destination.

Reset
REQ-025 rst_n=0 SHALL force the following regardless of clk: IDLE, Result=0, Cout=0, Overflow=0, Zero=0, busy=0, valid=0, counter=0, carry flop=0.
REQ-026 Reset during SHIFT SHALL abort the operation; no valid pulse is produced for it.
REQ-027 The first start after rst_n deasserts SHALL be accepted no earlier than the first rising edge with rst_n=1.

Structure
REQ-028 The package SHALL hold the state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10), the default width constant 32, and the counter width as clog2(W).
REQ-029 The one-bit add SHALL instantiate the team's existing gate-level full-adder cell (Full_Adder_Gate) once as the single sub-module; all other logic is local to the block.
REQ-030 The datapath SHALL contain no W-bit adder; area is O(W) flops plus one cell.

Verification
REQ-031 W=8, A=0x05, B=0x03, sub=0, start pulse -> valid 10 clocks later; Result=0x08, Cout=0, Overflow=0, Zero=0.
REQ-032 W=8, A=0x7F, B=0x01, sub=0 -> Result=0x80, Cout=0, Overflow=1; then A=0xFF, B=0x01 -> Result=0x00, Cout=1, Zero=1, Overflow=0.
REQ-033 W=8, A=0x03, B=0x05, sub=1 -> Result=0xFE, Cout=0 (borrow); A=0x80, B=0x01, sub=1 -> Result=0x7F, Overflow=1.
REQ-034 Mid-SHIFT, start pulsed with different operands -> ignored; first result unchanged and exactly one valid pulse.
REQ-035 rst_n low for 1 cycle at counter=3 -> outputs zero immediately (asynchronously), no valid; new start afterwards completes correctly.
REQ-036 W=32, 1000 random operand/sub pairs -> every Result/Cout/Overflow/Zero matches the reference model, and start-to-valid is always 34 clocks.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_sub_pkg
// Shared types and constants for the bit-serial adder/subtractor.
//   state_t   : FSM encoding (IDLE / SHIFT / DONE)
//   DEF_W     : default operand width
//   cnt_w()   : bit-counter width for a given operand width
// -----------------------------------------------------------------------------
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEF_W = 32;

  // The counter holds W-1 down to 0, which always fits in clog2(W) bits
  // for W >= 2.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// -----------------------------------------------------------------------------
// serial_add_sub_if
// Request/result bundle for serial_add_sub.
//   start, sub, A, B                     : request (master -> slave)
//   Result, Cout, Overflow, Zero,
//   busy, valid                          : status/result (slave -> master)
// -----------------------------------------------------------------------------
interface serial_add_sub_if
  import serial_add_sub_pkg::*;
#(
  parameter int W = DEF_W
) ();

  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Result;
  logic         Cout;
  logic         Overflow;
  logic         Zero;
  logic         busy;
  logic         valid;

  modport master (
    output start, sub, A, B,
    input  Result, Cout, Overflow, Zero, busy, valid
  );

  modport slave (
    input  start, sub, A, B,
    output Result, Cout, Overflow, Zero, busy, valid
  );

endinterface

// File: rtl/Full_Adder_Gate.sv
// -----------------------------------------------------------------------------
// Full_Adder_Gate
// One-bit gate-level full adder.
//   A, B, Cin : addend bits and carry in
//   S         : sum bit
//   Cout      : carry out
// -----------------------------------------------------------------------------
module Full_Adder_Gate (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic ab_x;
  logic ab_a;
  logic c_a;

  xor g_x0 (ab_x, A, B);
  xor g_x1 (S, ab_x, Cin);
  and g_a0 (ab_a, A, B);
  and g_a1 (c_a, ab_x, Cin);
  or  g_o0 (Cout, ab_a, c_a);

endmodule

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Bit-serial W-bit adder/subtractor using a single full-adder cell.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_sub_if slave
//           start/sub/A/B sampled in IDLE when no valid is pending;
//           Result, Cout, Overflow, Zero registered; busy in SHIFT;
//           valid is a one-cycle pulse W+2 clocks after start.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start (ignored while valid is high)
// SHIFT | one bit per clock through the full adder, LSB first
// DONE  | latch Cout/Overflow/Zero, raise valid on the next cycle
// -----------------------------------------------------------------------------
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_sub_if.slave  bus
);

  localparam int CW = cnt_w(W);

  state_t          state_q, state_d;
  logic [W-1:0]    sa_q, sa_d;
  logic [W-1:0]    sb_q, sb_d;
  logic [W-1:0]    res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cy_q, cy_d;
  logic            cmsb_q, cmsb_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
  logic            valid_q, valid_d;

  logic            fa_s;
  logic            fa_c;

  Full_Adder_Gate u_fa (
    .A    (sa_q[0]),
    .B    (sb_q[0]),
    .Cin  (cy_q),
    .S    (fa_s),
    .Cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    cmsb_d  = cmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // valid_q high means the previous result is still being presented;
        // a start in that cycle is dropped rather than queued.
        if (bus.start && !valid_q) begin
          sa_d    = bus.A;
          sb_d    = bus.sub ? ~bus.B : bus.B;
          cy_d    = bus.sub;
          cnt_d   = CW'(W - 1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        res_d = {fa_s, res_q[W-1:1]};
        sa_d  = {1'b0, sa_q[W-1:1]};
        sb_d  = {1'b0, sb_q[W-1:1]};
        cy_d  = fa_c;
        if (cnt_q == '0) begin
          // carry flop currently holds the carry into the MSB cell
          cmsb_d  = cy_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        cout_d  = cy_q;
        ovf_d   = cmsb_q ^ cy_q;
        zero_d  = (res_q == '0);
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Result   = res_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = ovf_q;
  assign bus.Zero     = zero_q;
  assign bus.busy     = (state_q == SHIFT);
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
// Self-checking bench: W=8 and W=32 instances, scoreboard queues of expected
// results, table-driven W=8 vectors, hand sequences for corner cases and a
// random W=32 run against a reference model.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_sub_if #(.W(8))  if8  ();
  serial_add_sub_if #(.W(32)) if32 ();

  serial_add_sub #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_add_sub #(.W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  typedef struct {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          stime;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  exp_t q8[$];
  exp_t q32[$];
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitors: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && if8.valid) begin
      if (q8.size() == 0) begin
        check("spurious_valid8", 64'(if8.valid), 64'd0);
      end else begin
        e = q8.pop_front();
        check("res8",  64'(if8.Result),   e.res);
        check("cout8", 64'(if8.Cout),     64'(e.cout));
        check("ovf8",  64'(if8.Overflow), 64'(e.ovf));
        check("zero8", 64'(if8.Zero),     64'(e.zero));
        check("lat8",  64'(cyc - e.stime), 64'd10);
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n && if32.valid) begin
      if (q32.size() == 0) begin
        check("spurious_valid32", 64'(if32.valid), 64'd0);
      end else begin
        e = q32.pop_front();
        check("res32",  64'(if32.Result),   e.res);
        check("cout32", 64'(if32.Cout),     64'(e.cout));
        check("ovf32",  64'(if32.Overflow), 64'(e.ovf));
        check("zero32", 64'(if32.Zero),     64'(e.zero));
        check("lat32",  64'(cyc - e.stime), 64'd34);
      end
    end
  end

  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] bb;
    logic [32:0] t;
    exp_t        e;
    bb      = s ? ~b : b;
    t       = {1'b0, a} + {1'b0, bb} + 33'(s);
    e.res   = 64'(t[31:0]);
    e.cout  = t[32];
    e.ovf   = (a[31] == bb[31]) && (t[31] != a[31]);
    e.zero  = (t[31:0] == 32'd0);
    e.stime = 0;
    return e;
  endfunction

  // Called at a negedge; start is accepted on the following posedge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [7:0] r, input logic co, input logic ov, input logic z);
    exp_t e;
    if8.A = a; if8.B = b; if8.sub = s; if8.start = 1'b1;
    e.res = 64'(r); e.cout = co; e.ovf = ov; e.zero = z; e.stime = cyc;
    q8.push_back(e);
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    if32.A = a; if32.B = b; if32.sub = s; if32.start = 1'b1;
    e = model32(a, b, s);
    e.stime = cyc;
    q32.push_back(e);
    @(negedge clk);
    if32.start = 1'b0;
  endtask

  // The extra negedge skips the valid cycle, during which start is ignored.
  task automatic wait_done8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q8.size() != 0) begin
      check("timeout8", 64'(q8.size()), 64'd0);
      q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done32();
    int n = 0;
    while (q32.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q32.size() != 0) begin
      check("timeout32", 64'(q32.size()), 64'd0);
      q32.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero8(input string tag);
    check({tag, "_res8"},   64'(if8.Result),   64'd0);
    check({tag, "_cout8"},  64'(if8.Cout),     64'd0);
    check({tag, "_ovf8"},   64'(if8.Overflow), 64'd0);
    check({tag, "_zero8"},  64'(if8.Zero),     64'd0);
    check({tag, "_busy8"},  64'(if8.busy),     64'd0);
    check({tag, "_valid8"}, 64'(if8.valid),    64'd0);
  endtask

  initial begin
    exp_t e;
    int   n;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{8'hFF, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0};

    if8.start  = 1'b0; if8.sub  = 1'b0; if8.A  = '0; if8.B  = '0;
    if32.start = 1'b0; if32.sub = 1'b0; if32.A = '0; if32.B = '0;

    #1 rst_n = 1'b0;
    #2;
    check_zero8("por");
    check("por_res32",   64'(if32.Result), 64'd0);
    check("por_valid32", 64'(if32.valid),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven W=8 vectors
    for (int i = 0; i < 10; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].res, tbl[i].cout, tbl[i].ovf, tbl[i].zero);
      wait_done8();
    end

    // start pulsed mid-SHIFT with other operands: ignored, flags held
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    if8.A = 8'hFF; if8.B = 8'hFF; if8.sub = 1'b1; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    check("mid_busy8", 64'(if8.busy),     64'd1);
    check("mid_cout8", 64'(if8.Cout),     64'd1);
    check("mid_ovf8",  64'(if8.Overflow), 64'd0);
    check("mid_zero8", 64'(if8.Zero),     64'd0);
    wait_done8();

    // start held through the valid cycle: accepted only on the next IDLE cycle
    op8(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!if8.valid && n < 100) begin @(negedge clk); n++; end
    check("b2b_valid_seen8", 64'(if8.valid), 64'd1);
    if8.A = 8'h01; if8.B = 8'h01; if8.sub = 1'b1; if8.start = 1'b1;
    e.res = 64'h00; e.cout = 1'b1; e.ovf = 1'b0; e.zero = 1'b1; e.stime = cyc + 1;
    q8.push_back(e);
    repeat (2) @(negedge clk);
    if8.start = 1'b0;
    wait_done8();

    // Reset at counter=3: outputs clear asynchronously, aborted op yields no valid
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done8();
    op8(8'h5A, 8'h0F, 1'b0, 8'h69, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_busy8", 64'(if8.busy), 64'd1);
    check("pre_rst_zero8", 64'(if8.Zero), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_zero8("rst");
    q8.delete();
    // start held across reset release: accepted on the first edge with rst_n=1
    if8.A = 8'h3C; if8.B = 8'h44; if8.sub = 1'b0; if8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e.res = 64'h80; e.cout = 1'b0; e.ovf = 1'b1; e.zero = 1'b0; e.stime = cyc;
    q8.push_back(e);
    @(negedge clk);
    if8.start = 1'b0;
    wait_done8();
    repeat (15) @(negedge clk);

    // Random W=32 against the reference model
    for (int i = 0; i < 1000; i++) begin
      op32($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_done32();
    end
    op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done32();
    op32(32'h0000_0000, 32'h0000_0001, 1'b1);
    wait_done32();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
